// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet constants, FSM state type and CRC-32 step
// Purpose: constants and the byte-wide reflected CRC-32 step used by TX and RX.
// Contents: ETH_PREAMBLE, ETH_SFD, ETH_CRC_POLY, ETH_CRC_INIT, ETH_CRC_RESIDUE,
//           tx_state_e, crc32_next().
package eth_pkg;

   localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
   localparam logic [7:0]  ETH_SFD         = 8'hD5;
   localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
   localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_ABORT,
      ST_DROP,
      ST_GAP
   } tx_state_e;

   // One byte through the reflected CRC-32, LSB of the byte first.
   function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
      logic [31:0] c;
      c = crc ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - byte-wide CRC-32 register with init and enable
// Purpose: running Ethernet CRC register, shared by the TX framer and RX checker.
// Ports: clk_i     clock
//        rst_i     synchronous active-high reset (loads ETH_CRC_INIT)
//        init_i    load ETH_CRC_INIT (wins over en_i)
//        en_i      fold data_i into the CRC
//        data_i    byte to fold
//        crc_o     current register value (not inverted)
module eth_crc32
   import eth_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   logic [31:0] crc_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || init_i) begin
         crc_q <= ETH_CRC_INIT;
      end else if (en_i) begin
         crc_q <= crc32_next(crc_q, data_i);
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII transmit framer: preamble, pad, FCS, underrun abort, IFG
// Purpose: wraps a byte stream (DA first) into a GMII frame with preamble/SFD,
//          zero padding to MIN_FRAME, CRC-32 FCS and an enforced inter-frame gap.
// Ports: clk_125  125 MHz byte clock
//        rst      synchronous active-high reset
//        s_data/s_valid/s_last/s_ready  upstream byte stream
//        tx_data/tx_en/tx_er            registered GMII outputs
//        busy     high whenever the FSM is not IDLE
module gmii_tx_framer
   import eth_pkg::*;
#(
   parameter int MIN_FRAME = 60,
   parameter int IFG_BYTES = 12
) (
   input  logic       clk_125,
   input  logic       rst,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic [7:0] tx_data,
   output logic       tx_en,
   output logic       tx_er,
   output logic       busy
);

   localparam logic [11:0] MIN_LEN = 12'(MIN_FRAME);
   // The IDLE arbitration cycle supplies the last idle byte-time of the gap.
   localparam logic [7:0]  GAP_LAST = 8'(IFG_BYTES - 2);

   tx_state_e   state_q;
   logic [10:0] cnt_q;
   logic [7:0]  aux_q;
   logic [7:0]  tx_data_q;
   logic        tx_en_q;
   logic        tx_er_q;

   logic [31:0] crc;
   logic [31:0] fcs_word;
   logic [11:0] cnt_inc;
   logic [10:0] cnt_sat;
   logic        crc_init;
   logic        crc_en;
   logic [7:0]  crc_din;

   assign s_ready  = (state_q == ST_DATA) || (state_q == ST_DROP);
   assign busy     = (state_q != ST_IDLE);
   assign tx_data  = tx_data_q;
   assign tx_en    = tx_en_q;
   assign tx_er    = tx_er_q;

   assign cnt_inc  = {1'b0, cnt_q} + 12'd1;
   assign cnt_sat  = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
   assign fcs_word = ~crc;

   assign crc_init = (state_q == ST_SFD);
   assign crc_en   = ((state_q == ST_DATA) && s_valid) || (state_q == ST_PAD);
   assign crc_din  = (state_q == ST_PAD) ? 8'h00 : s_data;

   eth_crc32 u_crc (
      .clk_i  (clk_125),
      .rst_i  (rst),
      .init_i (crc_init),
      .en_i   (crc_en),
      .data_i (crc_din),
      .crc_o  (crc)
   );

   // The state names the byte produced at the coming edge; outputs are the
   // bytes produced at the previous edge.
   always_ff @(posedge clk_125) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         aux_q     <= '0;
         tx_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
         tx_er_q   <= 1'b0;
      end else begin
         tx_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
         tx_er_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (s_valid) begin
                  state_q <= ST_PREAMBLE;
                  aux_q   <= '0;
                  cnt_q   <= '0;
               end
            end
            ST_PREAMBLE: begin
               tx_en_q   <= 1'b1;
               tx_data_q <= ETH_PREAMBLE;
               aux_q     <= aux_q + 8'd1;
               if (aux_q == 8'd6) state_q <= ST_SFD;
            end
            ST_SFD: begin
               tx_en_q   <= 1'b1;
               tx_data_q <= ETH_SFD;
               cnt_q     <= '0;
               state_q   <= ST_DATA;
            end
            ST_DATA: begin
               tx_en_q <= 1'b1;
               if (s_valid) begin
                  tx_data_q <= s_data;
                  cnt_q     <= cnt_sat;
                  if (s_last) begin
                     aux_q   <= '0;
                     state_q <= (cnt_inc < MIN_LEN) ? ST_PAD : ST_FCS;
                  end
               end else begin
                  tx_er_q <= 1'b1;
                  state_q <= ST_ABORT;
               end
            end
            ST_PAD: begin
               tx_en_q <= 1'b1;
               cnt_q   <= cnt_sat;
               if (cnt_inc >= MIN_LEN) begin
                  aux_q   <= '0;
                  state_q <= ST_FCS;
               end
            end
            ST_FCS: begin
               tx_en_q   <= 1'b1;
               tx_data_q <= fcs_word[{aux_q[1:0], 3'b000} +: 8];
               aux_q     <= aux_q + 8'd1;
               if (aux_q[1:0] == 2'd3) begin
                  aux_q   <= '0;
                  state_q <= ST_GAP;
               end
            end
            ST_ABORT: begin
               // s_last always exits DATA, so an underrun always has bytes left to drop.
               state_q <= ST_DROP;
            end
            ST_DROP: begin
               if (s_valid && s_last) begin
                  // The consumed s_last byte-time counts as the first idle byte of the gap.
                  aux_q   <= 8'd1;
                  state_q <= ST_GAP;
               end
            end
            ST_GAP: begin
               aux_q <= aux_q + 8'd1;
               if (aux_q >= GAP_LAST) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter MIN_FRAME, default 60, minimum bytes before FCS (DA+SA+type+payload+pad).
REQ-002 Parameter IFG_BYTES, default 12, idle byte-times enforced after each frame.
REQ-003 clk_125  input  1  byte clock, the same 125 MHz domain as the RX path; the block uses one clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_data  input  8  frame byte (DA first; no preamble/SFD/FCS).
REQ-006 s_valid  input  1  s_data valid.
REQ-007 s_last  input  1  marks final frame byte; qualified by s_valid.
REQ-008 s_ready  output  1  byte accepted when s_valid && s_ready.
REQ-009 tx_data  output  8  GMII byte toward the RGMII DDR output stage.
REQ-010 tx_en  output  1  GMII TX_EN.
REQ-011 tx_er  output  1  GMII TX_ER.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 tx_data, tx_en and tx_er SHALL be registered; s_ready SHALL be combinational from state only, never from s_valid.
REQ-014 States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT, DROP, GAP.
REQ-015 IDLE: s_ready=0, tx_en=0, tx_er=0, tx_data=0x00; s_valid=1 at edge N -> PREAMBLE, tx_en=1 with first 0x55 at edge N+1.
REQ-016 PREAMBLE: 7 bytes of 0x55, then SFD: 1 byte 0xD5, then DATA.
REQ-017 DATA: s_ready=1; each accepted byte is driven on tx_data the next cycle and fed to the CRC; byte counter increments, saturating at 2047 (11 bits).
REQ-018 DATA, s_last accepted: if count (including this byte) < MIN_FRAME -> PAD, else -> FCS.
REQ-019 PAD: s_ready=0; drive 0x00 with CRC update until count == MIN_FRAME, then FCS.
REQ-020 FCS: 4 bytes of ~crc, least-significant byte first; CRC reflected poly 0xEDB88320, init 0xFFFFFFFF at SFD; then GAP.
REQ-021 Underrun: s_valid=0 in DATA -> ABORT: one cycle tx_en=1, tx_er=1, tx_data=0x00; then DROP, or GAP if s_last was already accepted.
REQ-022 DROP: s_ready=1, tx_en=0; discard bytes until s_last accepted, then GAP.
REQ-023 GAP: tx_en=0, s_ready=0 for IFG_BYTES cycles; then IDLE; s_valid during GAP is held off, not lost.
REQ-024 Frames longer than 1518 bytes SHALL be transmitted unmodified; no truncation.
REQ-025 tx_er SHALL be 1 only in ABORT.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, tx_en=0, tx_er=0, tx_data=0x00, counters 0, CRC 0xFFFFFFFF, from the next cycle.
REQ-027 Reset mid-frame SHALL terminate tx_en immediately, without FCS or tx_er; no GAP follows; upstream is responsible for flushing its partial frame.

Structure
REQ-028 Shared package eth_pkg SHALL hold: ETH_PREAMBLE 8'h55, ETH_SFD 8'hD5, ETH_CRC_POLY 32'hEDB88320, ETH_CRC_INIT, ETH_CRC_RESIDUE 32'hDEBB20E3, the state enum.
REQ-029 Sub-module eth_crc32: byte-wide combinational next-CRC function plus register with init/enable, reusable by the RX checker.

Verification
REQ-030 14-byte frame (DA=FF..FF, SA=00:0A:35:00:00:01, type 0x0800) -> 7x55, D5, 14 bytes, 46x00, 4 FCS bytes; tx_en high exactly 72 cycles.
REQ-031 Reference-model check on any frame: CRC register run over the transmitted bytes after the SFD, including the FCS, ends at 0xDEBB20E3.
REQ-032 100-byte frame, then second frame offered on the cycle after s_last -> no pad; tx_en gap between the two frames exactly 12 cycles.
REQ-033 s_valid dropped at byte 20 of 64 -> one tx_er=1 cycle, no FCS, remaining 44 bytes consumed with tx_en=0, then 12-cycle GAP.
REQ-034 rst pulsed during byte 30 -> tx_en=0 the next cycle, busy=0, next frame starts cleanly with preamble.
REQ-035 Random s_valid with no gaps inside a frame, 1000 frames of 1-1600 bytes -> byte-exact match with the model, tx_er never set.
